slot_reel_engine: RTL
=====================

# slot_reel_engine

Parametrised slot-machine core: NUM_REELS reels of SYM_W-bit symbols, driven by an internal 16-bit XNOR Fibonacci LFSR, stopping one reel at a time on a tick strobe. It has rigged-win, rigged-lose and random outcomes, and flags a win when all reels match. It sits between the debounced button/switch inputs and the 7-segment multiplexer, replacing the fixed 4-digit slot FSM. An optional credit counter is compiled in by macro.

## Interface
- NUM_REELS, 4: number of reels, 2..8.
- SYM_W, 4: bits per reel symbol, 1..8.
- SPIN_TICKS, 8: tick strobes between successive reel stops, ≥1.
- CREDIT_W, 8: credit counter width; unused without SLOT_CREDITS_EN.
- PAYOUT, 5: credits added on a win.
- Clk  in  1  single clock. Every flop is on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- EIN  in  1  enable. Low forces OFF.
- tick  in  1  one-cycle pacing strobe from the clock divider.
- Submit  in  1  synchronised level. Acts on its rising edge only.
- rigged_win, rigged_lose  in  1 each  outcome mode switches.
- coin  in  1  one-cycle credit insert pulse. Ignored without the macro.
- reels  out  NUM_REELS*SYM_W  reel i at bits [i*SYM_W +: SYM_W].
- reel_stopped  out  NUM_REELS  bit i is high once reel i has settled.
- result_valid  out  1  one-cycle pulse when the outcome is final.
- win  out  1  all reels equal. Valid from result_valid until RESULT is left.
- busy  out  1  high in SETTLE.
- credits  out  CREDIT_W  credit count. Constant 0 without the macro.

## Operation
- LFSR: 16 bits, XNOR taps 16,15,13,4. Reset value 0. Advances every Clk cycle while not in reset. The all-ones lockup state is never reached from 0.
- States: OFF, SPIN, SETTLE, RESULT. Reset puts the block in OFF.
- Registered EIN low in any state: next state is OFF. In that transition, reels, reel_stopped and win clear; credits are retained.
- OFF: all outputs 0. When EIN is high, the next state is SPIN.
- SPIN: each unstopped reel i shows (lfsr[SYM_W-1:0] + i) mod 2^SYM_W, updated every cycle.
- SPIN, on a Submit rising edge (and credits > 0 when the macro is set):
  - Latch the mode: win if rigged_win and not rigged_lose; lose if rigged_lose and not rigged_win; random otherwise.
  - Clear the tick counter and go to SETTLE.
- SETTLE: reels stop in order 0 → NUM_REELS-1. Reel k stops on the (k+1)*SPIN_TICKS-th tick after entry. At the stop edge its value is captured and its reel_stopped bit is set.
  - Reel 0 captures lfsr[SYM_W-1:0] in every mode.
  - Win mode: every reel k>0 captures reel 0's value.
  - Lose mode: reels 1..N-2 capture reel 0's value; the last reel captures ~reel0, which is guaranteed to differ.
  - Random mode: reel k captures lfsr[SYM_W-1:0] at its own stop edge.
- The edge that stops the last reel moves the FSM to RESULT.
- RESULT:
  - result_valid is high in the first RESULT cycle only.
  - win = all reels equal, registered on RESULT entry.
  - Reels hold their values.
  - A Submit rising edge returns to SPIN: reel_stopped and win clear.
- Submit edges in SETTLE and OFF are ignored. Mode switches are sampled only at the accepting Submit edge.

## Timing
- Reset (asynchronous): state OFF, LFSR 0, all outputs 0, Submit edge register 0.
- A Submit edge seen at edge t (in SPIN) gives busy=1 from t+1.
- Total settle time is NUM_REELS*SPIN_TICKS ticks.
- result_valid asserts on the cycle after the last stop edge, for exactly one cycle.
- A tick on the SETTLE entry edge is not counted.
- EIN low is acted on at the next edge. It has priority over every transition, including a simultaneous Submit or last-reel stop.
- Asserting RST mid-SETTLE aborts the spin. The credit deduction is not refunded, because reset clears the credits.

## Configuration
- SLOT_CREDITS_EN defined: credit counter is present, reset value 0.
  - coin adds 1.
  - An accepted Submit in SPIN subtracts 1. Submit is refused (stays in SPIN) when credits = 0.
  - On RESULT entry with win, PAYOUT is added.
  - All additions saturate at 2^CREDIT_W-1. A coin and a payout on the same cycle are both applied, then saturated.
  - A coin on the same cycle as a deduction gives a net change of 0.
- SLOT_CREDITS_EN undefined: no counter. credits is tied to 0, coin is ignored, and Submit is never refused.

## Test plan
- Defaults, SPIN_TICKS=2, rigged_win=1, Submit edge → reel_stopped goes 0001, 0011, 0111, 1111 on ticks 2, 4, 6, 8. All four reels equal; result_valid is one cycle; win=1.
- rigged_lose=1 → reels 0..2 equal; reel3 = ~reel0 (e.g. reel0=4'hA, reel3=4'h5); win=0.
- Both switches set, 50 spins → reels match per-edge LFSR samples from the reference model; win matches the all-equal compare; no lockup.
- EIN dropped during reel 2 settle with a simultaneous Submit → OFF next cycle with all outputs 0. EIN re-raised → SPIN.
- SLOT_CREDITS_EN, credits=0 → Submit is ignored. 1 coin then a rigged win → credits 1→0→5. With CREDIT_W=3 at 7 plus a win → credits stay at 7.
- RST asserted mid-SETTLE, asynchronously between edges → outputs 0 immediately; state OFF.

Source files
------------

// File: rtl/slot_reel_engine.sv
// rtl/slot_reel_engine.sv - slot-machine reel core with LFSR symbols, staged reel stops and optional credits (SLOT_CREDITS_EN)
module slot_reel_engine #(
    parameter int NUM_REELS  = 4,
    parameter int SYM_W      = 4,
    parameter int SPIN_TICKS = 8,
    parameter int CREDIT_W   = 8,
    parameter int PAYOUT     = 5
) (
    input  logic                       Clk,
    input  logic                       RST,
    input  logic                       EIN,
    input  logic                       tick,
    input  logic                       Submit,
    input  logic                       rigged_win,
    input  logic                       rigged_lose,
    input  logic                       coin,
    output logic [NUM_REELS*SYM_W-1:0] reels,
    output logic [NUM_REELS-1:0]       reel_stopped,
    output logic                       result_valid,
    output logic                       win,
    output logic                       busy,
    output logic [CREDIT_W-1:0]        credits
);
    localparam int KW = $clog2(NUM_REELS);
    localparam int TW = $clog2(SPIN_TICKS + 1);

    typedef enum logic [1:0] {S_OFF, S_SPIN, S_SETTLE, S_RESULT} state_t;
    typedef enum logic [1:0] {M_RAND, M_WIN, M_LOSE} mode_t;

    state_t state, state_n;
    mode_t  mode_q, mode_in;

    logic [15:0]                          lfsr;
    logic                                 sub_q;
    logic [NUM_REELS-1:0][SYM_W-1:0]      reel_val;
    logic [NUM_REELS-1:0]                 stop_q;
    logic [KW-1:0]                        cur_k;
    logic [TW-1:0]                        tick_cnt;
    logic                                 rv_q;
    logic                                 win_q;
    logic                                 credit_ok;

    logic              sub_rise;
    logic              accept;
    logic              stop_edge;
    logic              last_k;
    logic              last_stop;
    logic [SYM_W-1:0]  lfsr_sym;
    logic [SYM_W-1:0]  cap_val;
    logic              win_next;

    assign sub_rise  = Submit & ~sub_q;
    assign lfsr_sym  = lfsr[SYM_W-1:0];
    assign accept    = EIN && (state == S_SPIN) && sub_rise && credit_ok;
    assign stop_edge = (state == S_SETTLE) && tick && (tick_cnt == TW'(SPIN_TICKS - 1));
    assign last_k    = (cur_k == KW'(NUM_REELS - 1));
    assign last_stop = EIN && stop_edge && last_k;
    assign mode_in   = (rigged_win && !rigged_lose) ? M_WIN :
                       (rigged_lose && !rigged_win) ? M_LOSE : M_RAND;

    // Value the current reel captures at its stop edge, and whether all reels will then match
    always_comb begin
        cap_val = lfsr_sym;
        if (cur_k != '0) begin
            case (mode_q)
                M_WIN:   cap_val = reel_val[0];
                M_LOSE:  cap_val = last_k ? ~reel_val[0] : reel_val[0];
                default: cap_val = lfsr_sym;
            endcase
        end
        win_next = 1'b1;
        for (int i = 0; i < NUM_REELS - 1; i++) begin
            if (reel_val[i] != cap_val) win_next = 1'b0;
        end
    end

    // State register
    always_ff @(posedge Clk or posedge RST) begin
        if (RST) state <= S_OFF;
        else     state <= state_n;
    end

    // Next-state logic; a low enable overrides every other transition
    always_comb begin
        state_n = state;
        if (!EIN) begin
            state_n = S_OFF;
        end else begin
            case (state)
                S_OFF:    state_n = S_SPIN;
                S_SPIN:   if (accept) state_n = S_SETTLE;
                S_SETTLE: if (last_stop) state_n = S_RESULT;
                S_RESULT: if (sub_rise) state_n = S_SPIN;
                default:  state_n = S_OFF;
            endcase
        end
    end

    // Outputs: unstopped reels follow the LFSR, stopped reels show their captured symbol
    always_comb begin
        reels = '0;
        busy  = (state == S_SETTLE);
        if (state != S_OFF) begin
            for (int i = 0; i < NUM_REELS; i++) begin
                reels[i*SYM_W +: SYM_W] = stop_q[i] ? reel_val[i] : SYM_W'(lfsr_sym + SYM_W'(i));
            end
        end
    end

    assign reel_stopped = stop_q;
    assign result_valid = rv_q;
    assign win          = win_q;

    // Free-running XNOR LFSR and Submit edge history
    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            lfsr  <= '0;
            sub_q <= 1'b0;
        end else begin
            lfsr  <= {lfsr[14:0], ~(lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3])};
            sub_q <= Submit;
        end
    end

    // Spin datapath: mode latch, tick pacing, reel capture and result flags
    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            mode_q   <= M_RAND;
            reel_val <= '0;
            stop_q   <= '0;
            cur_k    <= '0;
            tick_cnt <= '0;
            rv_q     <= 1'b0;
            win_q    <= 1'b0;
        end else begin
            rv_q <= 1'b0;
            if (!EIN) begin
                reel_val <= '0;
                stop_q   <= '0;
                win_q    <= 1'b0;
            end else begin
                case (state)
                    S_SPIN: begin
                        if (accept) begin
                            mode_q   <= mode_in;
                            cur_k    <= '0;
                            tick_cnt <= '0;
                        end
                    end
                    S_SETTLE: begin
                        if (stop_edge) begin
                            tick_cnt        <= '0;
                            reel_val[cur_k] <= cap_val;
                            stop_q[cur_k]   <= 1'b1;
                            cur_k           <= cur_k + KW'(1);
                            if (last_k) begin
                                rv_q  <= 1'b1;
                                win_q <= win_next;
                            end
                        end else if (tick) begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    S_RESULT: begin
                        if (sub_rise) begin
                            stop_q <= '0;
                            win_q  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SLOT_CREDITS_EN
    localparam int CMAX = (1 << CREDIT_W) - 1;
    logic [CREDIT_W-1:0] credit_q;
    int                  csum;

    // Coin, payout and deduction combine first, then saturate
    always_comb begin
        csum = int'(credit_q) + (coin ? 1 : 0) + ((last_stop && win_next) ? PAYOUT : 0) - (accept ? 1 : 0);
        if (csum > CMAX) csum = CMAX;
    end

    // Credit register survives enable drops, cleared only by reset
    always_ff @(posedge Clk or posedge RST) begin
        if (RST) credit_q <= '0;
        else     credit_q <= CREDIT_W'(csum);
    end

    assign credits   = credit_q;
    assign credit_ok = (credit_q != '0);
`else
    logic unused_cfg;
    assign unused_cfg = coin ^ (PAYOUT > 0);
    assign credits    = '0;
    assign credit_ok  = 1'b1;
`endif

endmodule
